// File: rtl/ripple_accumulator.sv
// ripple_accumulator: sequential controller around an external combinational
// ripple adder. It feeds the running total on A_bus and the incoming operand
// on B_bus, then registers S_bus back as the new total. A batch of N_OPS
// operands arrives over a valid/ready handshake. The total and a sticky
// unsigned-overflow flag leave over a valid/ready result port.
module ripple_accumulator #(
    parameter int WIDTH = 4,
    parameter int N_OPS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_data,
    output logic [WIDTH-1:0] A_bus,
    output logic [WIDTH-1:0] B_bus,
    input  logic [WIDTH-1:0] S_bus,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CNT_W = $clog2(N_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;
    logic               op_xfer;
    logic               wrap;

    // The handshake outputs depend only on the state (Moore style), so
    // neither port has a combinational path from its own valid/ready input.
    assign op_ready  = (state_reg == ACCUM);
    assign res_valid = (state_reg == DONE);
    assign ovf       = ovf_reg;
    assign op_xfer   = op_valid && (state_reg == ACCUM);

    // The adder does not expose its carry out. A carry out of the MSB
    // happened exactly when the modular sum is smaller than the accumulator.
    assign wrap = (S_bus < acc_reg);

    // Bus fan-out: the accumulator drives both the adder input and the
    // result port, and the operand passes straight through to the adder.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bus
            assign A_bus[gi]  = acc_reg[gi];
            assign result[gi] = acc_reg[gi];
            assign B_bus[gi]  = op_data[gi];
        end
    endgenerate

    // State register. Reset overrides everything, including a pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state logic. Every register holds its value unless a case changes it.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                // start is ignored here. Only accepted operands move the state.
                if (op_xfer) begin
                    acc_next = S_bus;
                    cnt_next = cnt_reg + CNT_W'(1);
                    ovf_next = ovf_reg | wrap;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // The result stays frozen until it is consumed. A start that
                // arrives together with res_ready is not remembered.
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ripple_accumulator.sv
// Directed testbench for ripple_accumulator. The bench models the external
// combinational adder. Each cycle it drives the inputs on the falling edge
// and checks the outputs shortly after that edge.
module tb_ripple_accumulator;

    localparam int WIDTH = 4;
    localparam int N_OPS = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] A_bus;
    logic [WIDTH-1:0] B_bus;
    logic [WIDTH-1:0] S_bus;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Model of the external 4-bit ripple adder: the sum modulo 2^WIDTH.
    assign S_bus = A_bus + B_bus;

    ripple_accumulator #(.WIDTH(WIDTH), .N_OPS(N_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .A_bus     (A_bus),
        .B_bus     (B_bus),
        .S_bus     (S_bus),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .ovf       (ovf)
    );

    typedef struct {
        logic             start;
        logic             op_valid;
        logic [WIDTH-1:0] op_data;
        logic             res_ready;
        logic             exp_op_ready;
        logic             exp_res_valid;
        logic [WIDTH-1:0] exp_result;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input logic e_rdy, input logic e_rv,
                       input logic [WIDTH-1:0] e_res, input logic e_ovf);
        vec_t t;
        t.start = s; t.op_valid = v; t.op_data = d; t.res_ready = r;
        t.exp_op_ready = e_rdy; t.exp_res_valid = e_rv;
        t.exp_result = e_res; t.exp_ovf = e_ovf;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then let them settle.
    task automatic step(input logic s, input logic v, input logic [WIDTH-1:0] d, input logic r);
        @(negedge clk);
        start = s; op_valid = v; op_data = d; res_ready = r;
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_rdy, input logic e_rv,
                             input logic [WIDTH-1:0] e_res, input logic e_ovf);
        check({tag, ".op_ready"},  32'(op_ready),  32'(e_rdy));
        check({tag, ".res_valid"}, 32'(res_valid), 32'(e_rv));
        check({tag, ".result"},    32'(result),    32'(e_res));
        check({tag, ".ovf"},       32'(ovf),       32'(e_ovf));
        $display("%s: start=%0b op_valid=%0b op_data=%0d res_ready=%0b -> op_ready=%0b res_valid=%0b result=%0d ovf=%0b",
                 tag, start, op_valid, op_data, res_ready, op_ready, res_valid, result, ovf);
    endtask

    initial begin
        int waited;
        rst = 1'b0; start = 1'b0; op_valid = 1'b0; op_data = '0; res_ready = 1'b0;

        // T1: hold reset for two edges while the other inputs are random.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); op_valid = 1'($urandom);
            op_data = WIDTH'($urandom); res_ready = 1'($urandom);
            @(negedge clk);
        end
        #1;
        check_out("T1_reset", 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0; start = 1'b0; op_valid = 1'b0; op_data = '0; res_ready = 1'b0;

        // T2: operands 1, 1, 2 give 4.
        //    s  v  d  rr  rdy rv res ovf
        add(1, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 1, 0,  1, 0, 0, 0);
        add(0, 1, 1, 0,  1, 0, 1, 0);
        add(0, 1, 2, 0,  1, 0, 2, 0);
        add(0, 0, 0, 1,  0, 1, 4, 0);
        add(0, 0, 0, 0,  0, 0, 4, 0);
        // T3: operands 9, 9, 1. The total wraps to 2, then reaches 3, and ovf sticks.
        add(1, 0, 0, 0,  0, 0, 4, 0);
        add(0, 1, 9, 0,  1, 0, 0, 0);
        add(0, 1, 9, 0,  1, 0, 9, 0);
        add(0, 1, 1, 0,  1, 0, 2, 1);
        add(0, 0, 0, 1,  0, 1, 3, 1);
        add(0, 0, 0, 0,  0, 0, 3, 1);
        // T6a: op_valid in IDLE is ignored.
        add(0, 1, 7, 0,  0, 0, 3, 1);
        add(0, 1, 7, 0,  0, 0, 3, 1);
        // T6b: start held during ACCUM and DONE changes nothing. The batch 4, 4, 4 gives 12.
        add(1, 0, 0, 0,  0, 0, 3, 1);
        add(1, 0, 0, 0,  1, 0, 0, 0);
        add(1, 1, 4, 0,  1, 0, 0, 0);
        add(1, 1, 4, 0,  1, 0, 4, 0);
        add(0, 1, 4, 0,  1, 0, 8, 0);
        add(1, 1, 5, 0,  0, 1, 12, 0);
        add(1, 0, 0, 1,  0, 1, 12, 0);
        add(0, 0, 0, 0,  0, 0, 12, 0);
        add(0, 0, 0, 0,  0, 0, 12, 0);

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].op_valid, vecs[i].op_data, vecs[i].res_ready);
            check_out($sformatf("vec%0d", i), vecs[i].exp_op_ready, vecs[i].exp_res_valid,
                      vecs[i].exp_result, vecs[i].exp_ovf);
        end

        // T4: operands 3, 0, 3 with two idle cycles between them, then 4 cycles of backpressure.
        step(1, 0, 0, 0); check_out("T4_start", 0, 0, 12, 0);
        step(0, 1, 3, 0); check_out("T4_op0", 1, 0, 0, 0);
        step(0, 0, 0, 0); check_out("T4_gap0a", 1, 0, 3, 0);
        step(0, 0, 0, 0); check_out("T4_gap0b", 1, 0, 3, 0);
        step(0, 1, 0, 0); check_out("T4_op1", 1, 0, 3, 0);
        step(0, 0, 0, 0); check_out("T4_gap1a", 1, 0, 3, 0);
        step(0, 0, 0, 0); check_out("T4_gap1b", 1, 0, 3, 0);
        step(0, 1, 3, 0); check_out("T4_op2", 1, 0, 3, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0); check_out($sformatf("T4_hold%0d", i), 0, 1, 6, 0);
        end
        step(0, 0, 0, 1); check_out("T4_consume", 0, 1, 6, 0);
        step(0, 0, 0, 0); check_out("T4_idle", 0, 0, 6, 0);

        // T5: reset in the middle of a batch, then run a clean batch of 1, 2, 3.
        step(1, 0, 0, 0); check_out("T5_start", 0, 0, 6, 0);
        step(0, 1, 5, 0); check_out("T5_op0", 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; op_valid = 1'b1; op_data = 4'd7; res_ready = 1'b0;
        @(negedge clk); #1;
        check_out("T5_reset", 0, 0, 0, 0);
        rst = 1'b0; op_valid = 1'b0; op_data = '0;
        step(1, 0, 0, 0); check_out("T5_restart", 0, 0, 0, 0);
        step(0, 1, 1, 0); check_out("T5_op1", 1, 0, 0, 0);
        step(0, 1, 2, 0); check_out("T5_op2", 1, 0, 1, 0);
        step(0, 1, 3, 0); check_out("T5_op3", 1, 0, 3, 0);
        waited = 0;
        step(0, 0, 0, 0);
        while (!res_valid && waited < 10) begin
            step(0, 0, 0, 0);
            waited++;
        end
        check("T5_latency_cycles", 32'(waited), 32'd0);
        check_out("T5_result", 0, 1, 6, 0);
        step(0, 0, 0, 1); check_out("T5_consume", 0, 1, 6, 0);
        step(0, 0, 0, 0); check_out("T5_idle", 0, 0, 6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
